// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: N requesters, registered one-hot grant held for up to weight[k] cycles.
// Optional owner lock is enabled by defining ARB_LOCK_EN; otherwise the lock input is ignored.
module wrr_arbiter #(
    parameter int N   = 16,
    parameter int WW  = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    input  logic            lock,
    output logic [N-1:0]    gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_vld
);

    logic [IDW-1:0] ptr;
    logic [WW-1:0]  burst_cnt;
    logic [WW-1:0]  wt [N];
    logic           hold;
    logic           found;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] win_next;
    logic [WW-1:0]  win_weight;
    logic [N-1:0]   win_onehot;
    logic [IDW-1:0] idx;
    int             sum;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            wt[i] = weight[i*WW +: WW];
        end
    end

    // Wrapping search starting at ptr; the first requester found wins.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        sum    = 0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            sum = int'(ptr) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = IDW'(sum);
            if (!found && req[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
    end

    always_comb begin
        win_onehot         = '0;
        win_onehot[win_id] = 1'b1;
        win_next           = (win_id == IDW'(N-1)) ? '0 : win_id + IDW'(1);
        win_weight         = (wt[win_id] == '0) ? WW'(1) : wt[win_id];
    end

`ifdef ARB_LOCK_EN
    assign hold = gnt_vld && req[gnt_id] && ((burst_cnt > WW'(1)) || lock);
`else
    logic unused_lock;
    assign unused_lock = lock;
    assign hold = gnt_vld && req[gnt_id] && (burst_cnt > WW'(1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_vld   <= 1'b0;
            ptr       <= '0;
            burst_cnt <= '0;
        end else if (hold) begin
            // Saturate at 1 so a locked owner keeps the grant without underflow.
            if (burst_cnt > WW'(1)) begin
                burst_cnt <= burst_cnt - WW'(1);
            end
        end else if (found) begin
            gnt       <= win_onehot;
            gnt_id    <= win_id;
            gnt_vld   <= 1'b1;
            ptr       <= win_next;
            burst_cnt <= win_weight;
        end else begin
            gnt       <= '0;
            gnt_vld   <= 1'b0;
            burst_cnt <= '0;
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(gnt) && (gnt_vld == (|gnt)));
`endif

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Parametrised weighted round-robin arbiter, successor to the fixed 16-way RR_arbiter. It arbitrates N requesters onto a shared resource with a registered one-hot grant. A grant can be held for up to a per-requester weight of consecutive cycles (a burst) before rotating. It also provides a binary grant index and grant-valid, and can optionally be locked by the owner.

Parameters:
N, 16, number of requesters (2..64)
WW, 4, weight width in bits; burst length per grant is 1..2^WW-1 cycles
IDW, $clog2(N), width of gnt_id

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-low reset (asserted at 0)
req  input  N  request vector, bit i = requester i
weight  input  N*WW  packed weights, weight[i*WW +: WW] for requester i, sampled at grant time
lock  input  1  owner holds grant beyond weight (only when ARB_LOCK_EN defined, else unused)
gnt  output  N  registered one-hot grant (all-zero when idle)
gnt_id  output  IDW  binary index of the granted requester
gnt_vld  output  1  |gnt, registered

Behaviour:
- Reset (rst=0, asynchronous, takes effect mid-cycle): gnt=0, gnt_id=0, gnt_vld=0, ptr=0, burst_cnt=0, owner invalid. Outputs stay at reset values until the first posedge after rst=1.
- State: ptr (IDW bits) is the search start; burst_cnt (WW bits) is the remaining cycles of the current burst; owner = gnt_id when gnt_vld=1.
- Latency: a grant appears 1 cycle after the posedge that samples req. Grant is never combinational from req.
- Each posedge, evaluate in this priority order:
  1. HOLD: gnt_vld=1, req[owner]=1 and burst_cnt>1 → keep gnt, burst_cnt--.
  2. REARB: otherwise, search req from ptr upward with wrap (ptr, ptr+1, ... N-1, 0, ... ptr-1). The first set bit k wins: gnt=1<<k, gnt_id=k, gnt_vld=1, ptr=(k+1) mod N, burst_cnt = weight[k] (weight 0 is treated as 1).
  3. IDLE: no req set → gnt=0, gnt_vld=0, gnt_id keeps its last value, ptr unchanged.
- Owner drops req mid-burst: the grant is released at the next posedge and REARB runs in that same edge. There is no idle bubble if another requester is active.
- Sole requester whose burst expires: REARB wraps back to it. The grant is continuous with no bubble and burst_cnt reloads.
- Fairness: every requester holding req continuously is granted within (N-1)*(2^WW-1)+1 cycles.
- ptr wrap: ptr=N-1 followed by a win at N-1 gives ptr=0. For non-power-of-2 N, ptr and gnt_id never exceed N-1.
- Weight changes during a burst do not affect the current burst. The new weight is sampled only on REARB.
- Invariant (assertion in RTL, `ifndef SYNTHESIS): $onehot0(gnt), and gnt_vld == |gnt.

Optional Feature:
ARB_LOCK_EN
- Defined: in HOLD, the condition becomes req[owner]=1 and (burst_cnt>1 or lock=1). While locked, burst_cnt saturates at 1 and does not decrement below it. When lock drops, the grant releases at the next edge, unless burst_cnt>1 (impossible after saturation). Dropping req always releases the grant regardless of lock.
- Not defined: the lock port exists but is ignored, and behaviour is pure weighted round-robin.

Test Plan:
- Reset: req=16'hFFFF running, pull rst=0 at mid-cycle (#4 after posedge) → gnt=0, gnt_vld=0 immediately without waiting for a clock. First grant after release is 16'h0001, one cycle after the first posedge with rst=1.
- All weights 1, req=16'hFFFF held → gnt = 0001, 0002, 0004 … 8000, 0001 on consecutive cycles; gnt_id = 0..15, 0.
- weight[0]=3, weight[5]=2, others 1, req=16'h0021 held → gnt = 0001 ×3, 0020 ×2, repeating; gnt_vld never drops.
- Sole requester req=16'h0100, weight[8]=2 held 10 cycles → gnt=16'h0100 continuously for 10 cycles, gnt_id=8. Drop req → gnt=0 at the next edge.
- Mid-burst drop: weight[2]=4, req=16'h0014 held, then drop bit 2 after 2 granted cycles → next edge gnt=16'h0010 (no bubble), ptr=5.
- ARB_LOCK_EN: weight[3]=1, req=16'h0009, lock=1 while owner=3 for 6 cycles → gnt=16'h0008 for 6 cycles. Drop lock → the next edge grants 16'h0001.
